// File: rtl/regex_feeder_pkg.sv
// Shared types and helpers for the regex trace feeder: FSM states, character pair
// layout and a saturating increment.
package regex_feeder_pkg;

  localparam int unsigned CHAR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  // One trace RAM word: lane B in the upper byte, lane A in the lower byte.
  typedef struct packed {
    logic [CHAR_W-1:0] lane_b;
    logic [CHAR_W-1:0] lane_a;
  } char_pair_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/feeder_trace_ram.sv
// Single-write single-read synchronous trace RAM with a registered read port.
module feeder_trace_ram
  import regex_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 2048,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned DW   = 2 * CHAR_W
) (
  input  logic          tb_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Contents deliberately carry no reset so a reset never disturbs a loaded trace.
  always_ff @(posedge tb_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/regex_trace_feeder.sv
// Streams a preloaded two-lane character trace on request and tallies per-regex match flags.
// Optional macro FEEDER_CYCLE_COUNT_EN enables the total_cycles run-length counter.
module regex_trace_feeder
  import regex_feeder_pkg::*;
#(
  parameter int unsigned TRACE_DEPTH  = 2048,
  parameter int unsigned NUM_REGEX    = 7,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned IDX_W        = 20,
  parameter int unsigned DRAIN_CYCLES = 2,
  localparam int unsigned AW          = $clog2(TRACE_DEPTH),
  localparam int unsigned RW          = (NUM_REGEX > 1) ? $clog2(NUM_REGEX) : 1
) (
  input  logic              tb_clk,
  input  logic              reset,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [CHAR_W-1:0] load_data_a,
  input  logic [CHAR_W-1:0] load_data_b,
  input  logic [AW:0]       trace_len,
  input  logic              start,
  input  logic              input_char_flag,
  output logic [CHAR_W-1:0] input_char,
  output logic [CHAR_W-1:0] input_char_2,
  input  logic [IDX_W-1:0]  i,
  input  logic              accepting_match_flag,
  input  logic              accepting_match_flag_2,
  input  logic [RW-1:0]     rd_idx,
  output logic [CNT_W-1:0]  rd_count_a,
  output logic [CNT_W-1:0]  rd_count_b,
  output logic [AW:0]       chars_sent,
  output logic              busy,
  output logic              done,
  output logic [31:0]       total_cycles
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  feeder_state_e r_state;
  feeder_state_e w_state_next;

  logic [LW-1:0]     r_ptr;
  logic [LW-1:0]     r_len;
  logic [LW-1:0]     r_chars_sent;
  logic [DW-1:0]     r_drain_cnt;
  logic              r_pend;
  logic              r_busy;
  logic              r_done;
  logic [CHAR_W-1:0] r_char_a;
  logic [CHAR_W-1:0] r_char_b;
  logic [CNT_W-1:0]  r_cnt_a [NUM_REGEX];
  logic [CNT_W-1:0]  r_cnt_b [NUM_REGEX];

  logic              w_load_ok;
  logic              w_start_ok;
  logic              w_req;
  logic              w_count_en;
  logic              w_idx_ok;
  logic [2*CHAR_W-1:0] w_rdata_raw;
  char_pair_t        w_rdata;

  assign w_load_ok  = load_we && ((r_state == IDLE) || (r_state == DONE));
  assign w_count_en = (r_state == RUN) || (r_state == DRAIN);
  assign w_idx_ok   = (i < IDX_W'(NUM_REGEX));
  assign w_rdata    = char_pair_t'(w_rdata_raw);

  feeder_trace_ram #(
    .DEPTH (TRACE_DEPTH)
  ) u_ram (
    .tb_clk  (tb_clk),
    .i_we    (w_load_ok),
    .i_waddr (load_addr),
    .i_wdata ({load_data_b, load_data_a}),
    .i_re    (w_req),
    .i_raddr (r_ptr[AW-1:0]),
    .o_rdata (w_rdata_raw)
  );

  // FSM state register.
  always_ff @(posedge tb_clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a request is only accepted while RUN.
  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start && (trace_len != '0)) begin
          w_state_next = RUN;
          w_start_ok   = 1'b1;
        end
      end
      RUN: begin
        if (input_char_flag) begin
          w_req = 1'b1;
          if (r_ptr == (r_len - LW'(1))) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (r_drain_cnt == DW'(DRAIN_CYCLES)) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Read pointer, delivery pipeline and status flags.
  always_ff @(posedge tb_clk) begin
    if (!reset) begin
      r_ptr        <= '0;
      r_len        <= '0;
      r_chars_sent <= '0;
      r_drain_cnt  <= '0;
      r_pend       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_char_a     <= '0;
      r_char_b     <= '0;
    end else begin
      r_busy <= (w_state_next == RUN) || (w_state_next == DRAIN);
      r_done <= (w_state_next == DONE);
      r_pend <= w_req;
      // RAM data lands one edge after the request; outputs hold otherwise.
      if (r_pend) begin
        r_char_a <= w_rdata.lane_a;
        r_char_b <= w_rdata.lane_b;
      end
      if (w_start_ok) begin
        r_ptr        <= '0;
        r_len        <= trace_len;
        r_chars_sent <= '0;
      end else if (w_req) begin
        r_ptr        <= r_ptr + LW'(1);
        r_chars_sent <= r_chars_sent + LW'(1);
      end
      if (r_state == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + DW'(1);
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  // Per-regex saturating match counters, cleared on reset and on each new run.
  always_ff @(posedge tb_clk) begin
    for (int k = 0; k < NUM_REGEX; k++) begin
      if (!reset || w_start_ok) begin
        r_cnt_a[k] <= '0;
        r_cnt_b[k] <= '0;
      end else if (w_count_en && w_idx_ok && (i == IDX_W'(k))) begin
        if (accepting_match_flag) begin
          r_cnt_a[k] <= CNT_W'(sat_inc(32'(r_cnt_a[k]), 32'(CNT_MAX)));
        end
        if (accepting_match_flag_2) begin
          r_cnt_b[k] <= CNT_W'(sat_inc(32'(r_cnt_b[k]), 32'(CNT_MAX)));
        end
      end
    end
  end

  // Combinational counter readback; out-of-range selects read zero.
  always_comb begin
    rd_count_a = '0;
    rd_count_b = '0;
    for (int k = 0; k < NUM_REGEX; k++) begin
      if (rd_idx == RW'(k)) begin
        rd_count_a = r_cnt_a[k];
        rd_count_b = r_cnt_b[k];
      end
    end
  end

`ifdef FEEDER_CYCLE_COUNT_EN
  logic [31:0] r_total;

  // Cycles spent in RUN or DRAIN, wrapping.
  always_ff @(posedge tb_clk) begin
    if (!reset) begin
      r_total <= '0;
    end else if (w_start_ok) begin
      r_total <= '0;
    end else if (w_count_en) begin
      r_total <= r_total + 32'd1;
    end
  end

  assign total_cycles = r_total;
`else
  assign total_cycles = '0;
`endif

  assign input_char   = r_char_a;
  assign input_char_2 = r_char_b;
  assign chars_sent   = r_chars_sent;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_regex_trace_feeder.sv
// Self-checking bench for regex_trace_feeder: scoreboarded character delivery, a table of
// match-flag vectors with counter models, and hand-written reset / start / load corner cases.
module tb_regex_trace_feeder;
  import regex_feeder_pkg::*;

  localparam int unsigned AW    = 11;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned SAT_W = 4;
  localparam int unsigned NR    = 7;
  localparam int unsigned IDX_W = 20;
  localparam int unsigned DRAIN = 2;

  logic              tb_clk;
  logic              reset;
  logic              load_we;
  logic [AW-1:0]     load_addr;
  logic [7:0]        load_data_a, load_data_b;
  logic [AW:0]       trace_len;
  logic              start;
  logic              input_char_flag;
  logic [7:0]        input_char, input_char_2;
  logic [IDX_W-1:0]  i;
  logic              accepting_match_flag, accepting_match_flag_2;
  logic [2:0]        rd_idx;
  logic [CNT_W-1:0]  rd_count_a, rd_count_b;
  logic [AW:0]       chars_sent;
  logic              busy, done;
  logic [31:0]       total_cycles;

  logic [7:0]        s_char_a, s_char_b;
  logic [SAT_W-1:0]  s_count_a, s_count_b;
  logic [AW:0]       s_chars_sent;
  logic              s_busy, s_done;
  logic [31:0]       s_total;

  regex_trace_feeder u_dut (
    .tb_clk(tb_clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data_a(load_data_a), .load_data_b(load_data_b), .trace_len(trace_len),
    .start(start), .input_char_flag(input_char_flag), .input_char(input_char),
    .input_char_2(input_char_2), .i(i), .accepting_match_flag(accepting_match_flag),
    .accepting_match_flag_2(accepting_match_flag_2), .rd_idx(rd_idx),
    .rd_count_a(rd_count_a), .rd_count_b(rd_count_b), .chars_sent(chars_sent),
    .busy(busy), .done(done), .total_cycles(total_cycles)
  );

  regex_trace_feeder #(.CNT_W(SAT_W)) u_sat (
    .tb_clk(tb_clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data_a(load_data_a), .load_data_b(load_data_b), .trace_len(trace_len),
    .start(start), .input_char_flag(input_char_flag), .input_char(s_char_a),
    .input_char_2(s_char_b), .i(i), .accepting_match_flag(accepting_match_flag),
    .accepting_match_flag_2(accepting_match_flag_2), .rd_idx(rd_idx),
    .rd_count_a(s_count_a), .rd_count_b(s_count_b), .chars_sent(s_chars_sent),
    .busy(s_busy), .done(s_done), .total_cycles(s_total)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int cyc = 0;
  always @(posedge tb_clk) cyc++;

  typedef struct {
    int idx; bit fa; bit fb; int reps;
    int chk; int exp_a; int exp_b;
  } vec_t;

  vec_t        tbl [6];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mem_m [16];
  logic [15:0] exp_q [$];
  int          ptr_m;
  int unsigned ma [NR], mb [NR], sa [NR], sb [NR];

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned msat(input int unsigned v, input int unsigned mx);
    return (v >= mx) ? v : v + 1;
  endfunction

  task automatic clear_models();
    for (int k = 0; k < NR; k++) begin
      ma[k] = 0; mb[k] = 0; sa[k] = 0; sb[k] = 0;
    end
  endtask

  task automatic load(input int addr, input logic [7:0] a, input logic [7:0] b);
    load_we = 1'b1; load_addr = AW'(addr); load_data_a = a; load_data_b = b;
    tick();
    load_we = 1'b0;
    mem_m[addr] = {b, a};
  endtask

  task automatic start_run(input int len);
    trace_len = (AW+1)'(len); start = 1'b1;
    tick();
    start = 1'b0;
    ptr_m = 0;
    clear_models();
  endtask

  // Issue one request; the scoreboard entry is checked one edge later.
  task automatic req(input string tag);
    logic [15:0] exp;
    input_char_flag = 1'b1;
    exp_q.push_back(mem_m[ptr_m]);
    ptr_m++;
    tick();
    input_char_flag = 1'b0;
    tick();
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, " char pair"}, 32'({input_char_2, input_char}), 32'(exp));
      check({tag, " sat char pair"}, 32'({s_char_b, s_char_a}), 32'(exp));
    end
  endtask

  task automatic apply_flags(input int idx, input bit fa, input bit fb, input bit counted);
    i = IDX_W'(idx); accepting_match_flag = fa; accepting_match_flag_2 = fb;
    tick();
    accepting_match_flag = 1'b0; accepting_match_flag_2 = 1'b0;
    if (counted && idx < NR) begin
      if (fa) begin ma[idx] = msat(ma[idx], 32'hF_FFFF); sa[idx] = msat(sa[idx], 15); end
      if (fb) begin mb[idx] = msat(mb[idx], 32'hF_FFFF); sb[idx] = msat(sb[idx], 15); end
    end
  endtask

  task automatic check_counters(input string tag);
    for (int k = 0; k < NR; k++) begin
      rd_idx = 3'(k);
      #1;
      check($sformatf("%s cnt_a[%0d]", tag, k), 32'(rd_count_a), ma[k]);
      check($sformatf("%s cnt_b[%0d]", tag, k), 32'(rd_count_b), mb[k]);
      check($sformatf("%s sat_a[%0d]", tag, k), 32'(s_count_a), sa[k]);
      check($sformatf("%s sat_b[%0d]", tag, k), 32'(s_count_b), sb[k]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    rd_idx = 3'd3;
    #1;
    check({tag, " input_char"}, 32'(input_char), 32'd0);
    check({tag, " input_char_2"}, 32'(input_char_2), 32'd0);
    check({tag, " chars_sent"}, 32'(chars_sent), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " total_cycles"}, total_cycles, 32'd0);
    check({tag, " cnt_a[3]"}, 32'(rd_count_a), 32'd0);
    check({tag, " cnt_b[3]"}, 32'(rd_count_b), 32'd0);
  endtask

  // Counts edges from the current (post-delivery) point until done rises.
  task automatic wait_done(input string tag, input int first);
    int k;
    k = first;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    check({tag, " done latency"}, 32'(k), 32'(DRAIN + 1));
  endtask

  initial begin
    int c_start;
    tbl[0] = '{3, 1'b1, 1'b0, 5, 3, 5, 0};
    tbl[1] = '{3, 1'b1, 1'b1, 2, 3, 7, 2};
    tbl[2] = '{7, 1'b1, 1'b1, 3, 3, 7, 2};
    tbl[3] = '{0, 1'b1, 1'b0, 2, 0, 2, 0};
    tbl[4] = '{6, 1'b0, 1'b1, 1, 6, 0, 1};
    tbl[5] = '{5, 1'b0, 1'b0, 2, 5, 0, 0};

    reset = 1'b0; load_we = 1'b0; load_addr = '0; load_data_a = '0; load_data_b = '0;
    trace_len = '0; start = 1'b0; input_char_flag = 1'b0; i = '0;
    accepting_match_flag = 1'b0; accepting_match_flag_2 = 1'b0; rd_idx = '0;
    ptr_m = 0;
    clear_models();
    tick(); tick();
    check_reset_state("reset");
    reset = 1'b1;
    tick();

    // Basic streaming with spaced requests.
    load(0, 8'h41, 8'h61); load(1, 8'h42, 8'h62); load(2, 8'h43, 8'h63); load(3, 8'h44, 8'h64);
    start_run(4);
    c_start = cyc;
    check("run busy", 32'(busy), 32'd1);
    check("run done", 32'(done), 32'd0);
    for (int n = 0; n < 3; n++) begin
      req($sformatf("t1 req%0d", n));
      tick(); tick();
      check($sformatf("t1 hold%0d", n), 32'({input_char_2, input_char}), 32'(mem_m[n]));
    end
    req("t1 req3");
    wait_done("t1", 1);
    check("t1 chars_sent", 32'(chars_sent), 32'd4);
    check("t1 busy", 32'(busy), 32'd0);
`ifdef FEEDER_CYCLE_COUNT_EN
    check("t1 total_cycles", total_cycles, 32'(cyc - c_start));
`else
    check("t1 total_cycles", total_cycles, 32'd0);
`endif
    // Requests in DONE are ignored.
    input_char_flag = 1'b1; tick(); tick(); input_char_flag = 1'b0; tick();
    check("done hold pair", 32'({input_char_2, input_char}), 32'h6444);
    check("done chars_sent", 32'(chars_sent), 32'd4);
    check("done still done", 32'(done), 32'd1);

    // Rerun without reload; match counting table.
    start_run(4);
    foreach (tbl[r]) begin
      for (int n = 0; n < tbl[r].reps; n++) apply_flags(tbl[r].idx, tbl[r].fa, tbl[r].fb, 1'b1);
      rd_idx = 3'(tbl[r].chk);
      #1;
      check($sformatf("tbl%0d cnt_a", r), 32'(rd_count_a), 32'(tbl[r].exp_a));
      check($sformatf("tbl%0d cnt_b", r), 32'(rd_count_b), 32'(tbl[r].exp_b));
    end
    check_counters("table");

    // Saturation on the narrow-counter instance.
    for (int n = 0; n < 20; n++) apply_flags(0, 1'b1, 1'b0, 1'b1);
    rd_idx = 3'd0;
    #1;
    check("sat cnt_a[0]", 32'(s_count_a), 32'd15);
    check("wide cnt_a[0]", 32'(rd_count_a), 32'd22);
    for (int n = 0; n < 3; n++) apply_flags(0, 1'b1, 1'b0, 1'b1);
    check("sat hold", 32'(s_count_a), 32'd15);
    check_counters("sat");

    // Reset mid-run after two characters.
    req("t5 req0");
    req("t5 req1");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    clear_models();
    check_reset_state("midrun reset");
    tick();
    start_run(4);
    for (int n = 0; n < 3; n++) apply_flags(1, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) req($sformatf("t5 rerun%0d", n));
    wait_done("t5", 1);
    for (int n = 0; n < 2; n++) apply_flags(1, 1'b1, 1'b1, 1'b0);
    check_counters("after done");
    // Zero-length start from DONE is ignored; a real start clears the counters.
    trace_len = '0; start = 1'b1; tick(); start = 1'b0;
    check("len0 from done", 32'(done), 32'd1);
    check_counters("len0 done");
    start_run(2);
    rd_idx = 3'd1;
    #1;
    check("start clears cnt", 32'(rd_count_a), 32'd0);
    check("restart busy", 32'(busy), 32'd1);

    // Zero-length start from IDLE; requests in IDLE ignored.
    reset = 1'b0; tick(); reset = 1'b1;
    trace_len = '0; start = 1'b1; tick(); start = 1'b0;
    input_char_flag = 1'b1; tick(); tick(); input_char_flag = 1'b0; tick();
    check("idle len0 busy", 32'(busy), 32'd0);
    check("idle len0 done", 32'(done), 32'd0);
    check("idle req ignored", 32'({input_char_2, input_char}), 32'd0);
    check("idle chars_sent", 32'(chars_sent), 32'd0);

    // Load and start on the same edge; load and start during RUN are ignored.
    load_we = 1'b1; load_addr = '0; load_data_a = 8'h5A; load_data_b = 8'h7A;
    trace_len = (AW+1)'(1); start = 1'b1;
    tick();
    mem_m[0] = 16'h7A5A; ptr_m = 0;
    load_data_a = 8'hEE; load_data_b = 8'hEE; trace_len = (AW+1)'(3);
    tick();
    load_we = 1'b0; start = 1'b0;
    req("t6 req0");
    wait_done("t6", 1);
    check("t6 chars_sent", 32'(chars_sent), 32'd1);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
